// File: rtl/booth_r8_digit_gen_if.sv
// Operand and digit-stream bundle between the radix-8 Booth digit generator and its neighbours.
// The slave modport is the generator's side; master is the driving/consuming side.
`timescale 1ns/1ps
interface booth_r8_digit_gen_if #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter int SIZE       = A_WIDTH + 2,
  parameter int NUM_DIGITS = (B_WIDTH + 3) / 3,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
  logic                      valid_i;
  logic                      ready_o;
  logic signed [A_WIDTH-1:0] a_i;
  logic signed [B_WIDTH-1:0] b_i;
  logic signed [SIZE-1:0]    mult_1_o;
  logic signed [SIZE-1:0]    mult_2_o;
  logic signed [SIZE-1:0]    mult_3_o;
  logic signed [SIZE-1:0]    mult_4_o;
  logic                      digit_valid_o;
  logic                      digit_ready_i;
  logic [3:0]                sel_o;
  logic [IDX_W-1:0]          digit_idx_o;
  logic                      last_o;

  modport master (
    output valid_i, a_i, b_i, digit_ready_i,
    input  ready_o, mult_1_o, mult_2_o, mult_3_o, mult_4_o,
    input  digit_valid_o, sel_o, digit_idx_o, last_o
  );

  modport slave (
    input  valid_i, a_i, b_i, digit_ready_i,
    output ready_o, mult_1_o, mult_2_o, mult_3_o, mult_4_o,
    output digit_valid_o, sel_o, digit_idx_o, last_o
  );
endinterface

// File: rtl/booth_r8_digit_gen.sv
// Radix-8 Booth recoder: latches A multiples for the partial-product mux and streams one
// sign/magnitude digit of B per handshake, least-significant digit first.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for operands; multiples from the previous product still held
// PREP  | form 3A from A and 2A
// EMIT  | present the current digit; advance on each downstream handshake
`timescale 1ns/1ps
module booth_r8_digit_gen #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int SIZE    = A_WIDTH + 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  booth_r8_digit_gen_if.slave bus
);

  localparam int NUM_DIGITS = (B_WIDTH + 3) / 3;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SR_W       = 3 * NUM_DIGITS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic signed [SIZE-1:0] mult_1_q, mult_1_d;
  logic signed [SIZE-1:0] mult_2_q, mult_2_d;
  logic signed [SIZE-1:0] mult_3_q, mult_3_d;
  logic signed [SIZE-1:0] mult_4_q, mult_4_d;
  logic [SR_W-1:0]        b_sr_q, b_sr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [SIZE-1:0] a_ext;
  logic [SR_W-1:0] b_load;
  logic            last;
  logic            digit_valid;
  logic            ready;
  logic [2:0]      mag;
  logic            neg;

  assign a_ext  = {{(SIZE-A_WIDTH){bus.a_i[A_WIDTH-1]}}, bus.a_i};
  // Trailing zero is the implicit b[-1] bit of the first Booth window.
  assign b_load = {{(SR_W-1-B_WIDTH){bus.b_i[B_WIDTH-1]}}, bus.b_i, 1'b0};
  assign last   = (state_q == EMIT) && (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    mult_1_d    = mult_1_q;
    mult_2_d    = mult_2_q;
    mult_3_d    = mult_3_q;
    mult_4_d    = mult_4_q;
    b_sr_d      = b_sr_q;
    idx_d       = idx_q;
    ready       = 1'b0;
    digit_valid = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.valid_i) begin
          mult_1_d = a_ext;
          mult_2_d = a_ext << 1;
          mult_4_d = a_ext << 2;
          b_sr_d   = b_load;
          idx_d    = '0;
          state_d  = PREP;
        end
      end
      PREP: begin
        mult_3_d = mult_1_q + mult_2_q;
        idx_d    = '0;
        state_d  = EMIT;
      end
      EMIT: begin
        digit_valid = 1'b1;
        if (bus.digit_ready_i) begin
          if (last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            b_sr_d = {{3{b_sr_q[SR_W-1]}}, b_sr_q[SR_W-1:3]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window {x3,x2,x1,x0} -> d = -4*x3 + 2*x2 + x1 + x0, with both zero windows unsigned.
  always_comb begin
    mag = 3'd0;
    neg = 1'b0;
    case (b_sr_q[3:0])
      4'b0000, 4'b1111: begin mag = 3'd0; neg = 1'b0; end
      4'b0001, 4'b0010: begin mag = 3'd1; neg = 1'b0; end
      4'b0011, 4'b0100: begin mag = 3'd2; neg = 1'b0; end
      4'b0101, 4'b0110: begin mag = 3'd3; neg = 1'b0; end
      4'b0111:          begin mag = 3'd4; neg = 1'b0; end
      4'b1000:          begin mag = 3'd4; neg = 1'b1; end
      4'b1001, 4'b1010: begin mag = 3'd3; neg = 1'b1; end
      4'b1011, 4'b1100: begin mag = 3'd2; neg = 1'b1; end
      4'b1101, 4'b1110: begin mag = 3'd1; neg = 1'b1; end
      default:          begin mag = 3'd0; neg = 1'b0; end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mult_1_q <= '0;
      mult_2_q <= '0;
      mult_3_q <= '0;
      mult_4_q <= '0;
      b_sr_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      mult_1_q <= mult_1_d;
      mult_2_q <= mult_2_d;
      mult_3_q <= mult_3_d;
      mult_4_q <= mult_4_d;
      b_sr_q   <= b_sr_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.digit_valid_o = digit_valid;
  assign bus.sel_o         = (state_q == EMIT) ? {neg, mag} : 4'b0000;
  assign bus.digit_idx_o   = idx_q;
  assign bus.last_o        = last;
  assign bus.mult_1_o      = mult_1_q;
  assign bus.mult_2_o      = mult_2_q;
  assign bus.mult_3_o      = mult_3_q;
  assign bus.mult_4_o      = mult_4_q;

endmodule
